// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer.
//   state_e                  - debouncer FSM state encoding
//   DEBOUNCE_DEFAULT_STABLE  - default number of stable samples to accept a level
package debounce_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT_STABLE = 4;

   typedef enum logic [1:0] {
      StIdle,      // debounced level 0, input agrees
      StRiseWait,  // debounced level 0, counting high samples
      StPressed,   // debounced level 1, input agrees
      StFallWait   // debounced level 1, counting low samples
   } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk - sampling clock
//   rst - synchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronized output, two clock edges behind d
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debouncer for a bouncy button/switch input.
// raw_i is synchronized, then a new level is accepted only after STABLE_CYCLES
// consecutive synchronized samples at that level.
//   clk     - sole clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   raw_i   - asynchronous, bouncy input
//   level_o - registered debounced level
//   rise_o  - one-cycle pulse in the first cycle level_o reads 1
//   fall_o  - one-cycle pulse in the first cycle level_o reads 0 after a 1
// Optional feature macro: DEBOUNCE_FALL_PULSE_EN. When undefined, fall_o is
// tied to 0 and the fall pulse logic is not built.
module button_debounce
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEBOUNCE_DEFAULT_STABLE,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic             sync_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw_i),
      .q   (sync_s)
   );

   // The first disagreeing sample already counts as 1, so the wait state
   // completes on the STABLE_CYCLES-th consecutive sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (sync_s) begin
               state_d = StRiseWait;
               cnt_d   = CntOne;
            end
         end
         StRiseWait: begin
            if (!sync_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StPressed: begin
            if (!sync_s) begin
               state_d = StFallWait;
               cnt_d   = CntOne;
            end
         end
         StFallWait: begin
            if (sync_s) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
      level_d = (state_d == StPressed) || (state_d == StFallWait);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= level_d & ~level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

`ifdef DEBOUNCE_FALL_PULSE_EN
   logic fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fall_q <= 1'b0;
      end else begin
         fall_q <= ~level_d & level_q;
      end
   end

   assign fall_o = fall_q;
`else
   assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: a hand-computed vector table for the
// STABLE_CYCLES=4 instance, a short sequence for a STABLE_CYCLES=2 instance, and
// randomized run-length stimulus checked against a run-length reference model.
module tb_button_debounce;

`ifdef DEBOUNCE_FALL_PULSE_EN
   localparam logic FALL_EN = 1'b1;
`else
   localparam logic FALL_EN = 1'b0;
`endif

   typedef struct {
      logic r;
      logic raw;
      logic lvl;
      logic rise;
      logic fall;
   } vec_t;

   // Reference: a 2-sample delay line, then the level flips once the number of
   // consecutive samples disagreeing with it reaches the stability threshold.
   typedef struct {
      logic h0;
      logic h1;
      int   run;
      logic level;
      logic rise;
      logic fall;
   } mdl_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw_i = 1'b0;
   logic level4, rise4, fall4;
   logic level2, rise2, fall2;

   int vectors = 0;
   int miscompares = 0;
   vec_t tbl[$];
   mdl_t m4, m2;

   always #5 clk = ~clk;

   button_debounce #(.STABLE_CYCLES(4)) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_i),
      .level_o (level4),
      .rise_o  (rise4),
      .fall_o  (fall4)
   );

   button_debounce #(.STABLE_CYCLES(2)) u_dut2 (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_i),
      .level_o (level2),
      .rise_o  (rise2),
      .fall_o  (fall2)
   );

   function automatic mdl_t mdl_step(mdl_t m, logic r, logic raw, int s);
      mdl_t n;
      logic samp;
      n      = m;
      n.rise = 1'b0;
      n.fall = 1'b0;
      if (r) begin
         n.h0    = 1'b0;
         n.h1    = 1'b0;
         n.run   = 0;
         n.level = 1'b0;
      end else begin
         samp = m.h1;
         n.h1 = m.h0;
         n.h0 = raw;
         n.run = (samp != m.level) ? m.run + 1 : 0;
         if (n.run == s) begin
            n.level = ~m.level;
            n.run   = 0;
            n.rise  = n.level;
            n.fall  = FALL_EN & ~n.level;
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp);
      end
   endtask

   // One clock: drive inputs, advance the models at the edge, check #1 later.
   task automatic apply(input logic r, input logic raw);
      rst   = r;
      raw_i = raw;
      @(posedge clk);
      m4 = mdl_step(m4, r, raw, 4);
      m2 = mdl_step(m2, r, raw, 2);
      #1;
      chk("model4 level", level4, m4.level);
      chk("model4 rise", rise4, m4.rise);
      chk("model4 fall", fall4, m4.fall);
      chk("model2 level", level2, m2.level);
      chk("model2 rise", rise2, m2.rise);
      chk("model2 fall", fall2, m2.fall);
      chk("rise/fall exclusive", rise4 & fall4, 1'b0);
      chk("cnt2 bound", u_dut2.cnt_q > 2'd1, 1'b0);
   endtask

   task automatic add(input logic r, input logic raw, input logic lvl, input logic rise,
                      input logic fall);
      vec_t v;
      v.r = r; v.raw = raw; v.lvl = lvl; v.rise = rise; v.fall = fall;
      tbl.push_back(v);
   endtask

   task automatic add_n(input int n, input logic r, input logic raw, input logic lvl);
      for (int i = 0; i < n; i++) add(r, raw, lvl, 1'b0, 1'b0);
   endtask

   initial begin
      m4 = '{h0: 1'b0, h1: 1'b0, run: 0, level: 1'b0, rise: 1'b0, fall: 1'b0};
      m2 = m4;

      // Table for the STABLE_CYCLES=4 instance.
      add_n(2, 1'b1, 1'b0, 1'b0);                  // reset
      add_n(5, 1'b0, 1'b1, 1'b0);                  // clean press
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);           // 6th edge: accepted
      add_n(1, 1'b0, 1'b1, 1'b1);
      add_n(5, 1'b0, 1'b0, 1'b1);                  // clean release
      add(1'b0, 1'b0, 1'b0, 1'b0, FALL_EN);
      add_n(1, 1'b0, 1'b0, 1'b0);
      add_n(3, 1'b0, 1'b1, 1'b0);                  // 3-cycle glitch
      add_n(8, 1'b0, 1'b0, 1'b0);
      add_n(1, 1'b0, 1'b1, 1'b0);                  // bounce 1,0,1,1,0
      add_n(1, 1'b0, 1'b0, 1'b0);
      add_n(2, 1'b0, 1'b1, 1'b0);
      add_n(1, 1'b0, 1'b0, 1'b0);
      add_n(5, 1'b0, 1'b1, 1'b0);                  // then held high
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      add_n(2, 1'b0, 1'b1, 1'b1);
      add_n(5, 1'b0, 1'b0, 1'b1);                  // release again
      add(1'b0, 1'b0, 1'b0, 1'b0, FALL_EN);
      add_n(1, 1'b0, 1'b0, 1'b0);
      add_n(4, 1'b0, 1'b1, 1'b0);                  // reach RISE_WAIT count=2
      add_n(1, 1'b1, 1'b1, 1'b0);                  // reset mid-wait
      add_n(5, 1'b0, 1'b1, 1'b0);                  // raw still high
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      add_n(1, 1'b0, 1'b1, 1'b1);

      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].raw);
         chk($sformatf("tbl[%0d] level", i), level4, tbl[i].lvl);
         chk($sformatf("tbl[%0d] rise", i), rise4, tbl[i].rise);
         chk($sformatf("tbl[%0d] fall", i), fall4, tbl[i].fall);
      end

      // Minimum threshold: accepted on exactly the 4th edge.
      apply(1'b1, 1'b0);
      apply(1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         apply(1'b0, 1'b1);
         chk($sformatf("s2 edge%0d level", i), level2, 1'b0);
      end
      apply(1'b0, 1'b1);
      chk("s2 edge4 level", level2, 1'b1);
      chk("s2 edge4 rise", rise2, 1'b1);
      apply(1'b0, 1'b1);
      chk("s2 edge5 rise", rise2, 1'b0);

      // Randomized run-length stimulus with occasional reset.
      begin
         logic raw = 1'b0;
         int   run_len = 0;
         for (int c = 0; c < 2000; c++) begin
            if (run_len == 0) begin
               raw     = ~raw;
               run_len = $urandom_range(1, 7);
            end
            run_len--;
            apply(($urandom_range(0, 199) == 0), raw);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
